exu_wb_arbiter: RTL and testbench

Shares the single register-file write port between the execute-stage functional units (ALU, MUL, DIV, LSU, CSR). It accepts one write-back request per cycle from up to `NUM_SRC` units, grants exactly one, registers the winning result, and drives the register file and commit logic. Losing units see `ready_o` low and hold their result, which stalls their output stage.

---
 rtl/exu_wb_arbiter_if.sv | 24 ++
 rtl/exu_wb_arbiter.sv | 100 ++++++++++
 tb/tb_exu_wb_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/exu_wb_arbiter_if.sv
// Write-back request bundle between the execute units and the arbiter.
// Fields are packed per source: source k sits at [k*W +: W].
interface exu_wb_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int IDW     = 3
);
    logic [NUM_SRC-1:0]     req_i;
    logic [NUM_SRC*DW-1:0]  wdata_i;
    logic [NUM_SRC*AW-1:0]  waddr_i;
    logic [NUM_SRC*IDW-1:0] cid_i;
    logic [NUM_SRC-1:0]     ready_o;

    modport master (
        output req_i, wdata_i, waddr_i, cid_i,
        input  ready_o
    );

    modport slave (
        input  req_i, wdata_i, waddr_i, cid_i,
        output ready_o
    );
endinterface

// File: rtl/exu_wb_arbiter.sv
// Register-file write-back arbiter for the execute-stage units.
// WB_ARB_RR_EN selects round-robin; otherwise fixed priority (index 0 wins).
module exu_wb_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int IDW     = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    exu_wb_arbiter_if.slave src,
    input  logic           flush_i,
    output logic           reg_we_o,
    output logic [AW-1:0]  reg_waddr_o,
    output logic [DW-1:0]  reg_wdata_o,
    output logic           commit_valid_o,
    output logic [IDW-1:0] commit_id_o,
    output logic           busy_o
);
    localparam int IXW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] grant;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_data;
    logic [IDW-1:0]     sel_cid;
    logic               xfer;

`ifdef WB_ARB_RR_EN
    logic [IXW-1:0] ptr;
    logic [IXW-1:0] gidx;
    int             j;

    // Search begins one past the last winner and wraps.
    always_comb begin
        grant    = '0;
        gidx     = '0;
        sel_addr = '0;
        sel_data = '0;
        sel_cid  = '0;
        j        = 0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            j = (int'(ptr) + i) % NUM_SRC;
            if (src.req_i[j] && grant == '0) begin
                grant[j] = 1'b1;
                gidx     = IXW'(j);
                sel_addr = src.waddr_i[j*AW +: AW];
                sel_data = src.wdata_i[j*DW +: DW];
                sel_cid  = src.cid_i[j*IDW +: IDW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= IXW'(NUM_SRC - 1);
        end else if (xfer) begin
            ptr <= gidx;
        end
    end
`else
    always_comb begin
        grant    = '0;
        sel_addr = '0;
        sel_data = '0;
        sel_cid  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src.req_i[i] && grant == '0) begin
                grant[i] = 1'b1;
                sel_addr = src.waddr_i[i*AW +: AW];
                sel_data = src.wdata_i[i*DW +: DW];
                sel_cid  = src.cid_i[i*IDW +: IDW];
            end
        end
    end
`endif

    // Flush and reset both suppress the grant, so no transfer is taken.
    assign src.ready_o = (flush_i || !rst_n) ? '0 : grant;
    assign xfer        = |src.ready_o;
    assign busy_o      = |(src.req_i & (src.req_i - NUM_SRC'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_we_o       <= 1'b0;
            commit_valid_o <= 1'b0;
            reg_waddr_o    <= '0;
            reg_wdata_o    <= '0;
            commit_id_o    <= '0;
        end else if (xfer) begin
            reg_we_o       <= (sel_addr != '0);
            commit_valid_o <= 1'b1;
            reg_waddr_o    <= sel_addr;
            reg_wdata_o    <= sel_data;
            commit_id_o    <= sel_cid;
        end else begin
            reg_we_o       <= 1'b0;
            commit_valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_exu_wb_arbiter.sv
// Scoreboard bench for exu_wb_arbiter: directed grants, x0, flush, reset.
// Expected grant sequences follow the WB_ARB_RR_EN build setting.
module tb_exu_wb_arbiter;
    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        commit_valid_o;
    logic [2:0]  commit_id_o;
    logic        busy_o;

    exu_wb_arbiter_if #(.NUM_SRC(4), .DW(32), .AW(5), .IDW(3)) bus ();

    exu_wb_arbiter #(.NUM_SRC(4), .DW(32), .AW(5), .IDW(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .src            (bus.slave),
        .flush_i        (flush_i),
        .reg_we_o       (reg_we_o),
        .reg_waddr_o    (reg_waddr_o),
        .reg_wdata_o    (reg_wdata_o),
        .commit_valid_o (commit_valid_o),
        .commit_id_o    (commit_id_o),
        .busy_o         (busy_o)
    );

    typedef struct {
        int          due;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [2:0]  cid;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [4:0]  sa [4];
    logic [31:0] sd [4];
    logic [2:0]  sc [4];
    logic [3:0]  held_exp [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    // Monitor: every cycle either the due commit appears or the outputs idle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                chk("commit_valid", 64'(commit_valid_o), 64'(1'b1));
                chk("reg_we", 64'(reg_we_o), 64'(e.we));
                chk("reg_waddr", 64'(reg_waddr_o), 64'(e.addr));
                chk("reg_wdata", 64'(reg_wdata_o), 64'(e.data));
                chk("commit_id", 64'(commit_id_o), 64'(e.cid));
            end else begin
                chk("idle_commit_valid", 64'(commit_valid_o), 64'(1'b0));
                chk("idle_reg_we", 64'(reg_we_o), 64'(1'b0));
            end
        end
    end

    task automatic step(logic [3:0] req, logic fl, logic [3:0] er,
                        logic eb, string n);
        exp_t e;
        bus.req_i = req;
        flush_i   = fl;
        #1;
        chk({n, "_ready"}, 64'(bus.ready_o), 64'(er));
        chk({n, "_busy"}, 64'(busy_o), 64'(eb));
        for (int k = 0; k < 4; k++) begin
            if (er[k]) begin
                e.due  = cyc + 1;
                e.we   = (sa[k] != 5'd0);
                e.addr = sa[k];
                e.data = sd[k];
                e.cid  = sc[k];
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(string n);
        chk({n, "_we"}, 64'(reg_we_o), 64'(1'b0));
        chk({n, "_cv"}, 64'(commit_valid_o), 64'(1'b0));
        chk({n, "_addr"}, 64'(reg_waddr_o), 64'(5'd0));
        chk({n, "_data"}, 64'(reg_wdata_o), 64'(32'd0));
        chk({n, "_cid"}, 64'(commit_id_o), 64'(3'd0));
        chk({n, "_ready"}, 64'(bus.ready_o), 64'(4'd0));
    endtask

    task automatic rst_pulse(string n);
        rst_n = 1'b0;
        #1;
        chk_zero(n);
        q.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        sa[0] = 5'd5;  sd[0] = 32'hDEADBEEF; sc[0] = 3'd2;
        sa[1] = 5'd7;  sd[1] = 32'h11111111; sc[1] = 3'd1;
        sa[2] = 5'd0;  sd[2] = 32'h22222222; sc[2] = 3'd6;
        sa[3] = 5'd31; sd[3] = 32'h33333333; sc[3] = 3'd3;
`ifdef WB_ARB_RR_EN
        held_exp[0] = 4'b0001; held_exp[1] = 4'b0010;
        held_exp[2] = 4'b0100; held_exp[3] = 4'b1000;
`else
        held_exp[0] = 4'b0001; held_exp[1] = 4'b0001;
        held_exp[2] = 4'b0001; held_exp[3] = 4'b0001;
`endif
        for (int k = 0; k < 4; k++) begin
            bus.waddr_i[k*5 +: 5]   = sa[k];
            bus.wdata_i[k*32 +: 32] = sd[k];
            bus.cid_i[k*3 +: 3]     = sc[k];
        end
        rst_n     = 1'b0;
        flush_i   = 1'b0;
        bus.req_i = 4'b1111;
        #2;
        chk_zero("reset");
        bus.req_i = 4'b0000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        step(4'b0001, 1'b0, 4'b0001, 1'b0, "single");
        step(4'b0100, 1'b0, 4'b0100, 1'b0, "x0");
        step(4'b0000, 1'b0, 4'b0000, 1'b0, "idle0");
        step(4'b0000, 1'b0, 4'b0000, 1'b0, "idle1");
        rst_pulse("rst_a");

        step(4'b1111, 1'b0, 4'b0001, 1'b1, "drop0");
        step(4'b1110, 1'b0, 4'b0010, 1'b1, "drop1");
        step(4'b1100, 1'b0, 4'b0100, 1'b1, "drop2");
        step(4'b1000, 1'b0, 4'b1000, 1'b0, "drop3");

        for (int c = 0; c < 4; c++)
            step(4'b1111, 1'b0, held_exp[c], 1'b1, "held");

        step(4'b0011, 1'b1, 4'b0000, 1'b1, "flush");
        chk("flush_next_we", 64'(reg_we_o), 64'(1'b0));
        chk("flush_next_cv", 64'(commit_valid_o), 64'(1'b0));
        step(4'b0011, 1'b0, 4'b0001, 1'b1, "after_flush");
        step(4'b0110, 1'b0, 4'b0010, 1'b1, "pair");
        step(4'b0000, 1'b0, 4'b0000, 1'b0, "idle2");

        step(4'b0001, 1'b0, 4'b0001, 1'b0, "pre_rst");
        chk("pre_rst_cv", 64'(commit_valid_o), 64'(1'b1));
        rst_pulse("mid_rst");
        step(4'b1010, 1'b0, 4'b0010, 1'b1, "post_rst");
        step(4'b1000, 1'b0, 4'b1000, 1'b0, "post_rst2");
        step(4'b0000, 1'b0, 4'b0000, 1'b0, "drain0");
        step(4'b0000, 1'b0, 4'b0000, 1'b0, "drain1");

        chk("queue_empty", 64'(q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
